// File: rtl/floor_position_tracker_if.sv
// Sense/command bundle between the elevator controller and floor_position_tracker.
// The controller side (master) drives the raw sensors and commands; the tracker (slave) returns position.
interface floor_position_tracker_if;
  logic [1:0] elevator_control;
  logic       floor_marker;
  logic       bottom_limit;
  logic [3:0] top_floor;
  logic       clear_fault;
  logic [3:0] current_floor;
  logic       at_floor;
  logic       position_valid;
  logic       fault;

  modport master (
    output elevator_control, floor_marker, bottom_limit, top_floor, clear_fault,
    input  current_floor, at_floor, position_valid, fault
  );

  modport slave (
    input  elevator_control, floor_marker, bottom_limit, top_floor, clear_fault,
    output current_floor, at_floor, position_valid, fault
  );
endinterface

// File: rtl/floor_position_tracker.sv
// Tracks the car's floor from a debounced vane marker, bottom limit switch and motor direction.
// Optional missed-vane watchdog is built when FLOOR_TRACK_TIMEOUT_EN is defined.
module floor_position_tracker #(
  parameter int BOTTOM_FLOOR    = 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  floor_position_tracker_if.slave  trk
);

  localparam logic [3:0] BOTTOM = 4'(BOTTOM_FLOOR);
  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("floor_position_tracker: DEBOUNCE_CYCLES or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {HOMING, TRACK, FAULT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  logic       marker_s1_q, marker_s2_q;
  logic       bottom_s1_q, bottom_s2_q;
  logic [3:0] db_cnt_q, db_cnt_d;
  logic       marker_db_q, marker_db_d;
  logic       marker_db_prev_q;

  state_t     state_q;
  dir_t       last_dir_q;
  logic [3:0] floor_q;
  logic       valid_q;
  logic       fault_q;

  logic       marker_rise;
  logic       moving;
  logic       resync;
  logic       wd_expired;

  // Debounce: count consecutive synchronised samples that disagree with the filtered value.
  always_comb begin
    db_cnt_d    = 4'd0;
    marker_db_d = marker_db_q;
    if (marker_s2_q != marker_db_q) begin
      if (db_cnt_q + 4'd1 == DB_MAX) begin
        marker_db_d = ~marker_db_q;
      end else begin
        db_cnt_d = db_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      marker_s1_q      <= 1'b0;
      marker_s2_q      <= 1'b0;
      bottom_s1_q      <= 1'b0;
      bottom_s2_q      <= 1'b0;
      db_cnt_q         <= 4'd0;
      marker_db_q      <= 1'b0;
      marker_db_prev_q <= 1'b0;
    end else begin
      marker_s1_q      <= trk.floor_marker;
      marker_s2_q      <= marker_s1_q;
      bottom_s1_q      <= trk.bottom_limit;
      bottom_s2_q      <= bottom_s1_q;
      db_cnt_q         <= db_cnt_d;
      marker_db_q      <= marker_db_d;
      marker_db_prev_q <= marker_db_q;
    end
  end

  assign marker_rise = marker_db_q & ~marker_db_prev_q;
  assign moving      = (trk.elevator_control == 2'b01) || (trk.elevator_control == 2'b10);
  assign resync      = bottom_s2_q && marker_db_q && (floor_q != BOTTOM);

`ifdef FLOOR_TRACK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wd_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else if (state_q != TRACK || marker_rise || !moving) begin
      wd_cnt_q <= '0;
    end else if (!marker_db_q) begin
      wd_cnt_q <= wd_cnt_q + TO_W'(1);
    end
  end

  // Fires on the cycle the count would reach the limit, so FAULT is entered on that edge.
  assign wd_expired = (state_q == TRACK) && moving && !marker_db_q && !marker_rise &&
                      (wd_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HOMING;
      last_dir_q <= DIR_NONE;
      floor_q    <= BOTTOM;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      if (trk.elevator_control == 2'b01) begin
        last_dir_q <= DIR_UP;
      end else if (trk.elevator_control == 2'b10) begin
        last_dir_q <= DIR_DOWN;
      end

      case (state_q)
        HOMING: begin
          valid_q <= 1'b0;
          fault_q <= 1'b0;
          if (bottom_s2_q && marker_db_q) begin
            floor_q <= BOTTOM;
            valid_q <= 1'b1;
            state_q <= TRACK;
          end
        end
        TRACK: begin
          if (resync) begin
            floor_q <= BOTTOM;
          end else if (marker_rise) begin
            // Counting never wraps: any step past either end is a tracking loss.
            case (last_dir_q)
              DIR_UP: begin
                if (floor_q == trk.top_floor || floor_q == 4'd15) begin
                  state_q <= FAULT;
                  fault_q <= 1'b1;
                  valid_q <= 1'b0;
                end else begin
                  floor_q <= floor_q + 4'd1;
                end
              end
              DIR_DOWN: begin
                if (floor_q == BOTTOM || floor_q == 4'd0) begin
                  state_q <= FAULT;
                  fault_q <= 1'b1;
                  valid_q <= 1'b0;
                end else begin
                  floor_q <= floor_q - 4'd1;
                end
              end
              default: begin
                state_q <= FAULT;
                fault_q <= 1'b1;
                valid_q <= 1'b0;
              end
            endcase
          end else if (wd_expired) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        FAULT: begin
          fault_q <= 1'b1;
          valid_q <= 1'b0;
          if (trk.clear_fault) begin
            state_q    <= HOMING;
            fault_q    <= 1'b0;
            last_dir_q <= DIR_NONE;
          end
        end
        default: begin
          state_q <= HOMING;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign trk.current_floor  = floor_q;
  assign trk.position_valid = valid_q;
  assign trk.fault          = fault_q;
  assign trk.at_floor       = marker_db_q & valid_q;

endmodule

// File: tb/tb_floor_position_tracker.sv
// Self-checking bench for floor_position_tracker: homing, counting, glitch rejection,
// top/bottom faults, resync priority, optional watchdog and asynchronous reset.
module tb_floor_position_tracker;

  localparam logic [1:0] C_STOP = 2'b00;
  localparam logic [1:0] C_UP   = 2'b01;
  localparam logic [1:0] C_DOWN = 2'b10;

  logic clk;
  logic rst;

  floor_position_tracker_if bus();

  floor_position_tracker #(
    .BOTTOM_FLOOR   (1),
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trk(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] floor;
    logic       fault;
    logic       valid;
  } exp_t;

  typedef struct {
    logic [1:0] ctrl;
    logic [3:0] top;
    logic [3:0] exp_floor;
    logic       exp_fault;
  } vec_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [3:0] m_floor;
  logic       m_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One clean 8-cycle vane pulse; the expected result is queued at stimulus time
  // and popped on the cycle after marker_rise, when the floor must have updated.
  task automatic pulse(input logic [1:0] ctrl, input logic [3:0] ef, input logic efault);
    exp_t e;
    e.floor = ef;
    e.fault = efault;
    e.valid = !efault;
    sb_q.push_back(e);
    bus.elevator_control = ctrl;
    bus.floor_marker     = 1'b1;
    tick(6);
    check("floor_before_update", 32'(bus.current_floor), 32'(m_floor));
    check("at_floor_with_marker", 32'(bus.at_floor), 32'(m_valid));
    tick(1);
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("floor_after_rise", 32'(bus.current_floor), 32'(e.floor));
      check("fault_after_rise", 32'(bus.fault), 32'(e.fault));
      check("valid_after_rise", 32'(bus.position_valid), 32'(e.valid));
      m_floor = e.floor;
      m_valid = e.valid;
    end
    tick(1);
    bus.floor_marker = 1'b0;
    tick(10);
  endtask

  task automatic home_and_release();
    bus.elevator_control = C_STOP;
    bus.bottom_limit     = 1'b1;
    bus.floor_marker     = 1'b1;
    tick(10);
    check("home_floor", 32'(bus.current_floor), 32'd1);
    check("home_valid", 32'(bus.position_valid), 32'd1);
    check("home_at_floor", 32'(bus.at_floor), 32'd1);
    check("home_fault", 32'(bus.fault), 32'd0);
    bus.bottom_limit = 1'b0;
    bus.floor_marker = 1'b0;
    tick(10);
    m_floor = 4'd1;
    m_valid = 1'b1;
  endtask

  initial begin
    vec_t vecs[6];
    logic seen_at_floor;

    vecs[0] = '{C_UP, 4'd5, 4'd2, 1'b0};
    vecs[1] = '{C_UP, 4'd5, 4'd3, 1'b0};
    vecs[2] = '{C_UP, 4'd5, 4'd4, 1'b0};
    vecs[3] = '{C_UP, 4'd5, 4'd5, 1'b0};
    vecs[4] = '{C_UP, 4'd5, 4'd5, 1'b1};
    vecs[5] = '{C_UP, 4'd5, 4'd5, 1'b1};

    rst                  = 1'b1;
    bus.elevator_control = C_STOP;
    bus.floor_marker     = 1'b0;
    bus.bottom_limit     = 1'b0;
    bus.top_floor        = 4'd5;
    bus.clear_fault      = 1'b0;
    m_floor              = 4'd1;
    m_valid              = 1'b0;
    tick(3);
    check("reset_floor", 32'(bus.current_floor), 32'd1);
    check("reset_valid", 32'(bus.position_valid), 32'd0);
    check("reset_fault", 32'(bus.fault), 32'd0);
    check("reset_at_floor", 32'(bus.at_floor), 32'd0);
    rst = 1'b0;
    tick(2);

    home_and_release();

    // 3-sample glitch must never reach the debounced marker.
    bus.elevator_control = C_UP;
    bus.floor_marker     = 1'b1;
    seen_at_floor        = 1'b0;
    tick(3);
    bus.floor_marker = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen_at_floor = seen_at_floor | bus.at_floor;
    end
    check("glitch_at_floor", 32'(seen_at_floor), 32'd0);
    check("glitch_floor", 32'(bus.current_floor), 32'd1);

    for (int i = 0; i < 6; i++) begin
      bus.top_floor = vecs[i].top;
      pulse(vecs[i].ctrl, vecs[i].exp_floor, vecs[i].exp_fault);
    end

    bus.clear_fault = 1'b1;
    tick(1);
    bus.clear_fault = 1'b0;
    check("clear_fault_drop", 32'(bus.fault), 32'd0);
    check("clear_valid_low", 32'(bus.position_valid), 32'd0);
    tick(2);
    home_and_release();

    pulse(C_UP, 4'd2, 1'b0);
    pulse(C_UP, 4'd3, 1'b0);
    bus.elevator_control = C_DOWN;
    tick(3);
    pulse(C_STOP, 4'd2, 1'b0);

    // Bottom limit plus marker away from floor 1: resync beats the coincident DOWN rise.
    bus.elevator_control = C_STOP;
    bus.bottom_limit     = 1'b1;
    bus.floor_marker     = 1'b1;
    tick(10);
    check("resync_floor", 32'(bus.current_floor), 32'd1);
    check("resync_fault", 32'(bus.fault), 32'd0);
    check("resync_valid", 32'(bus.position_valid), 32'd1);
    bus.bottom_limit = 1'b0;
    bus.floor_marker = 1'b0;
    tick(10);
    m_floor = 4'd1;
    m_valid = 1'b1;

    pulse(C_UP, 4'd2, 1'b0);
    bus.elevator_control = C_UP;
    tick(80);
`ifdef FLOOR_TRACK_TIMEOUT_EN
    check("watchdog_fault", 32'(bus.fault), 32'd1);
`else
    check("watchdog_fault", 32'(bus.fault), 32'd0);
`endif

    // Asynchronous reset mid-cycle takes effect before the next clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_floor", 32'(bus.current_floor), 32'd1);
    check("async_rst_valid", 32'(bus.position_valid), 32'd0);
    check("async_rst_fault", 32'(bus.fault), 32'd0);
    check("async_rst_at_floor", 32'(bus.at_floor), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
